// File: rtl/rename_unit.sv
// Single-wide register rename stage: speculative RAT, circular free list,
// committed RAT for flush recovery, and in-order recycling of old mappings.
module rename_unit #(
  parameter int unsigned NUM_AREGS = 32,
  parameter int unsigned NUM_PREGS = 128,
  parameter int unsigned AREG_W    = $clog2(NUM_AREGS),
  parameter int unsigned PREG_W    = $clog2(NUM_PREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AREG_W-1:0] in_rs1,
  input  logic [AREG_W-1:0] in_rs2,
  input  logic [AREG_W-1:0] in_rd,
  input  logic              in_regwrite,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PREG_W-1:0] out_prs1,
  output logic [PREG_W-1:0] out_prs2,
  output logic [PREG_W-1:0] out_prd,
  output logic [PREG_W-1:0] out_old_prd,
  output logic              out_alloc,
  input  logic              commit_valid,
  input  logic              commit_alloc,
  input  logic [AREG_W-1:0] commit_rd,
  input  logic [PREG_W-1:0] commit_prd,
  input  logic [PREG_W-1:0] commit_old_prd,
  input  logic              flush
);
  localparam int unsigned FL_DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int unsigned FL_W     = $clog2(FL_DEPTH);
  localparam int unsigned CNT_W    = $clog2(FL_DEPTH + 1);

  logic [PREG_W-1:0] rat  [NUM_AREGS];
  logic [PREG_W-1:0] crat [NUM_AREGS];
  logic [PREG_W-1:0] fl   [FL_DEPTH];
  logic [FL_W-1:0]   head, tail, commit_head;
  logic [FL_W-1:0]   head_inc, tail_inc, commit_head_inc;
  logic [CNT_W-1:0]  fl_count, spec_count;
  logic              alloc, accept, acc_alloc, commit_push;

  // Handshake and pointer-increment logic.
  always_comb begin
    alloc       = in_regwrite && (in_rd != '0);
    in_ready    = !flush && (!out_valid || out_ready) && ((fl_count != '0) || !alloc);
    accept      = in_valid && in_ready;
    acc_alloc   = accept && alloc;
    commit_push = commit_valid && commit_alloc;
    head_inc        = (head == FL_W'(FL_DEPTH - 1)) ? '0 : head + FL_W'(1);
    tail_inc        = (tail == FL_W'(FL_DEPTH - 1)) ? '0 : tail + FL_W'(1);
    commit_head_inc = (commit_head == FL_W'(FL_DEPTH - 1)) ? '0 : commit_head + FL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_AREGS); i++) begin
        rat[i]  <= PREG_W'(i);
        crat[i] <= PREG_W'(i);
      end
      for (int i = 0; i < int'(FL_DEPTH); i++) begin
        fl[i] <= PREG_W'(int'(NUM_AREGS) + i);
      end
      head        <= '0;
      tail        <= '0;
      commit_head <= '0;
      fl_count    <= CNT_W'(FL_DEPTH);
      spec_count  <= '0;
      out_valid   <= 1'b0;
      out_prs1    <= '0;
      out_prs2    <= '0;
      out_prd     <= '0;
      out_old_prd <= '0;
      out_alloc   <= 1'b0;
    end else begin
      // Commit is applied first so a same-cycle flush sees its effect.
      if (commit_push) begin
        fl[tail]    <= commit_old_prd;
        tail        <= tail_inc;
        commit_head <= commit_head_inc;
        if (commit_rd != '0) crat[commit_rd] <= commit_prd;
      end

      if (flush) begin
        for (int i = 0; i < int'(NUM_AREGS); i++) rat[i] <= crat[i];
        if (commit_push && (commit_rd != '0)) rat[commit_rd] <= commit_prd;
        head       <= commit_push ? commit_head_inc : commit_head;
        // Post-commit (fl+1)+(spec-1) equals the pre-commit sum.
        fl_count   <= fl_count + spec_count;
        spec_count <= '0;
        out_valid  <= 1'b0;
      end else begin
        fl_count   <= fl_count + CNT_W'(commit_push) - CNT_W'(acc_alloc);
        spec_count <= spec_count + CNT_W'(acc_alloc) - CNT_W'(commit_push);
        if (accept) begin
          out_valid <= 1'b1;
          out_prs1  <= rat[in_rs1];
          out_prs2  <= rat[in_rs2];
          out_alloc <= alloc;
          if (alloc) begin
            out_prd     <= fl[head];
            out_old_prd <= rat[in_rd];
            rat[in_rd]  <= fl[head];
            head        <= head_inc;
          end else begin
            out_prd     <= '0;
            out_old_prd <= '0;
          end
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  a_no_fl_overflow: assert property (@(posedge clk) disable iff (reset)
    !(commit_push && (fl_count == CNT_W'(FL_DEPTH))));
  a_no_spurious_commit: assert property (@(posedge clk) disable iff (reset)
    !(commit_push && (spec_count == '0)));

endmodule

// File: tb/tb_rename_unit.sv
// Directed bench for rename_unit: allocation, x0 handling, free-list wrap,
// commit/flush recovery and output back-pressure.
module tb_rename_unit;
  logic       clk, reset;
  logic       in_valid, in_ready, in_regwrite;
  logic [4:0] in_rs1, in_rs2, in_rd;
  logic       out_valid, out_ready, out_alloc;
  logic [6:0] out_prs1, out_prs2, out_prd, out_old_prd;
  logic       commit_valid, commit_alloc, flush;
  logic [4:0] commit_rd;
  logic [6:0] commit_prd, commit_old_prd;

  int n_checks = 0;
  int n_fail   = 0;

  rename_unit dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_regwrite(in_regwrite),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prs1(out_prs1), .out_prs2(out_prs2), .out_prd(out_prd),
    .out_old_prd(out_old_prd), .out_alloc(out_alloc),
    .commit_valid(commit_valid), .commit_alloc(commit_alloc), .commit_rd(commit_rd),
    .commit_prd(commit_prd), .commit_old_prd(commit_old_prd),
    .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_regwrite = 0;
    out_ready = 1;
    commit_valid = 0; commit_alloc = 0; commit_rd = 0; commit_prd = 0; commit_old_prd = 0;
    flush = 0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic rename(input int rs1, input int rs2, input int rd, input bit rw);
    in_valid = 1; in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_rd = 5'(rd); in_regwrite = rw;
    out_ready = 1;
    step();
    in_valid = 0;
  endtask

  task automatic set_commit(input int rd, input int prd, input int old);
    commit_valid = 1; commit_alloc = 1;
    commit_rd = 5'(rd); commit_prd = 7'(prd); commit_old_prd = 7'(old);
  endtask

  task automatic clear_commit();
    commit_valid = 0; commit_alloc = 0;
  endtask

  initial begin
    // 1: reset state and basic rename with a dependent follower
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_prd", out_prd, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_fl_count", dut.fl_count, 96);
    rename(1, 2, 5, 1);
    check("t1a_valid", out_valid, 1);
    check("t1a_prs1", out_prs1, 1);
    check("t1a_prs2", out_prs2, 2);
    check("t1a_prd", out_prd, 32);
    check("t1a_old", out_old_prd, 5);
    check("t1a_alloc", out_alloc, 1);
    rename(5, 5, 6, 1);
    check("t1b_prs1", out_prs1, 32);
    check("t1b_prs2", out_prs2, 32);
    check("t1b_prd", out_prd, 33);
    check("t1b_old", out_old_prd, 6);
    step();
    check("t1_drain_valid", out_valid, 0);

    // 2: no allocation for rd=x0 or RegWrite=0
    do_reset();
    rename(3, 0, 0, 1);
    check("t2a_alloc", out_alloc, 0);
    check("t2a_prd", out_prd, 0);
    check("t2a_old", out_old_prd, 0);
    check("t2a_prs1", out_prs1, 3);
    check("t2a_prs2", out_prs2, 0);
    rename(0, 4, 7, 0);
    check("t2b_alloc", out_alloc, 0);
    check("t2b_prd", out_prd, 0);
    check("t2b_prs2", out_prs2, 4);
    rename(0, 0, 9, 1);
    check("t2c_prd_head_unchanged", out_prd, 32);
    check("t2c_x0_map", out_prs1, 0);

    // 3: exhaust the free list, recycle one preg, wrap head
    do_reset();
    for (int i = 0; i < 96; i++) begin
      rename(1, 2, ((i + 4) % 31) + 1, 1);
      if (i == 0)  check("t3_first_prd", out_prd, 32);
      if (i == 95) check("t3_last_prd", out_prd, 127);
    end
    check("t3_fl_empty", dut.fl_count, 0);
    in_valid = 1; in_rd = 7; in_regwrite = 1;
    #1;
    check("t3_full_in_ready", in_ready, 0);
    set_commit(5, 32, 5);
    step();
    clear_commit();
    check("t3_ready_after_commit", in_ready, 1);
    check("t3_idle_valid", out_valid, 0);
    step();
    in_valid = 0;
    check("t3_recycled_prd", out_prd, 5);
    check("t3_recycled_alloc", out_alloc, 1);
    in_valid = 1;
    #1;
    check("t3_full_again", in_ready, 0);
    in_valid = 0;
    check("t3_head_wrapped", dut.head, 1);

    // 4: commit older rename, flush younger one
    do_reset();
    rename(0, 0, 5, 1);
    check("t4_prd_a", out_prd, 32);
    rename(0, 0, 5, 1);
    check("t4_prd_b", out_prd, 33);
    check("t4_old_b", out_old_prd, 32);
    set_commit(5, 32, 5);
    step();
    clear_commit();
    flush = 1;
    #1;
    check("t4_flush_in_ready", in_ready, 0);
    step();
    flush = 0;
    check("t4_flush_valid", out_valid, 0);
    check("t4_flush_spec", dut.spec_count, 0);
    rename(5, 0, 8, 1);
    check("t4_rat5", out_prs1, 32);
    check("t4_next_alloc", out_prd, 33);
    check("t4_fl_count", dut.fl_count, 95);

    // 5: flush coinciding with commit of the last in-flight rename
    do_reset();
    rename(0, 0, 5, 1);
    check("t5_prd", out_prd, 32);
    set_commit(5, 32, 5);
    flush = 1;
    step();
    clear_commit();
    flush = 0;
    check("t5_spec", dut.spec_count, 0);
    check("t5_fl_count", dut.fl_count, 96);
    rename(5, 0, 3, 1);
    check("t5_rat5", out_prs1, 32);
    check("t5_next_alloc", out_prd, 33);
    check("t5_old", out_old_prd, 3);

    // 6: back-pressure keeps outputs stable and blocks allocation
    do_reset();
    in_valid = 1; in_rs1 = 1; in_rs2 = 2; in_rd = 5; in_regwrite = 1; out_ready = 0;
    step();
    in_rd = 6;
    check("t6_first_prd", out_prd, 32);
    for (int c = 0; c < 3; c++) begin
      check("t6_hold_in_ready", in_ready, 0);
      step();
      check("t6_hold_valid", out_valid, 1);
      check("t6_hold_prd", out_prd, 32);
      check("t6_hold_old", out_old_prd, 5);
    end
    check("t6_no_alloc", dut.fl_count, 95);
    out_ready = 1;
    #1;
    check("t6_release_ready", in_ready, 1);
    step();
    in_valid = 0;
    check("t6_next_prd", out_prd, 33);
    check("t6_next_old", out_old_prd, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
